// File: rtl/rv32i_memory_access.sv
// rv32i_memory_access: RV32I MEM stage, data-bus req/gnt/rvalid sequencing, store lane alignment and load extension
module rv32i_memory_access #(
    parameter int MISALIGN_TRAP  = 1,
    parameter int RVALID_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        execute_valid,
    input  logic        execute_load,
    input  logic        execute_store,
    input  logic        execute_reg_write,
    input  logic [2:0]  execute_funct3,
    input  logic [4:0]  execute_rd,
    input  logic [31:0] execute_alu_result,
    input  logic [31:0] execute_rs2_data,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        memory_stall,
    output logic        memory_wb_en,
    output logic [4:0]  memory_rd,
    output logic [31:0] memory_wb_data,
    output logic        memory_misaligned,
    output logic        memory_bus_error
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [1:0]  a, al;
    logic        is_byte, is_half, trap, expire;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] load_data;
    assign a       = execute_alu_result[1:0];
    assign is_byte = execute_funct3[1:0] == 2'b00;
    assign is_half = execute_funct3[1:0] == 2'b01;
    assign trap    = (MISALIGN_TRAP != 0) && (is_half ? a[0] : (!is_byte && a != 2'b00));
    // lane forced to the natural boundary when misaligned accesses are not trapped
    assign al      = is_byte ? a : is_half ? {a[1], 1'b0} : 2'b00;
    assign lb      = dmem_rdata[{lane, 3'b000} +: 8];
    assign lh      = dmem_rdata[{lane[1], 4'b0000} +: 16];
    assign load_data = f3[1:0] == 2'b00 ? {{24{lb[7] & ~f3[2]}}, lb} :
                       f3[1:0] == 2'b01 ? {{16{lh[15] & ~f3[2]}}, lh} : dmem_rdata;
    assign expire  = (RVALID_TIMEOUT != 0) && (cnt + 32'd1 == 32'(RVALID_TIMEOUT));
    assign dmem_req     = state == REQ;
    assign memory_stall = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            f3                <= '0;
            lane              <= '0;
            dmem_we           <= 1'b0;
            dmem_be           <= '0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            memory_wb_en      <= 1'b0;
            memory_rd         <= '0;
            memory_wb_data    <= '0;
            memory_misaligned <= 1'b0;
            memory_bus_error  <= 1'b0;
        end else begin
            memory_wb_en      <= 1'b0;
            memory_misaligned <= 1'b0;
            memory_bus_error  <= 1'b0;
            case (state)
                IDLE: if (execute_valid) begin
                    if (execute_load || execute_store) begin
                        if (trap) memory_misaligned <= 1'b1;
                        else begin
                            state      <= REQ;
                            cnt        <= '0;
                            dmem_we    <= !execute_load;
                            dmem_addr  <= {execute_alu_result[31:2], 2'b00};
                            dmem_be    <= is_byte ? 4'b0001 << al : is_half ? 4'b0011 << al : 4'hF;
                            dmem_wdata <= is_byte ? {4{execute_rs2_data[7:0]}} :
                                          is_half ? {2{execute_rs2_data[15:0]}} : execute_rs2_data;
                            f3         <= execute_funct3;
                            lane       <= al;
                            memory_rd  <= execute_rd;
                        end
                    end else begin
                        memory_wb_en   <= execute_reg_write && execute_rd != 5'd0;
                        memory_wb_data <= execute_alu_result;
                        memory_rd      <= execute_rd;
                    end
                end
                REQ: begin
                    cnt <= cnt + 32'd1;
                    if (dmem_gnt) state <= dmem_we ? IDLE : WAIT;
                    else if (expire) begin
                        state            <= IDLE;
                        memory_bus_error <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (dmem_rvalid) begin
                        state          <= IDLE;
                        memory_wb_en   <= memory_rd != 5'd0;
                        memory_wb_data <= load_data;
                    end else if (expire) begin
                        state            <= IDLE;
                        memory_bus_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_memory_access.sv
// tb_rv32i_memory_access: directed checks of the MEM stage, trapping/timeout instance plus a non-trapping instance
module tb_rv32i_memory_access;
    logic        clk = 0, reset = 1;
    logic        execute_valid = 0, execute_load = 0, execute_store = 0, execute_reg_write = 0;
    logic [2:0]  execute_funct3 = 0;
    logic [4:0]  execute_rd = 0;
    logic [31:0] execute_alu_result = 0, execute_rs2_data = 0;
    logic        dmem_gnt = 0, dmem_rvalid = 0;
    logic [31:0] dmem_rdata = 0;
    logic        req, we, stall, wb_en, mis, berr;
    logic [3:0]  be;
    logic [31:0] addr, wdata, wb_data;
    logic [4:0]  rd;
    logic        req2, we2, stall2, wb_en2, mis2, berr2;
    logic [3:0]  be2;
    logic [31:0] addr2, wdata2, wb_data2;
    logic [4:0]  rd2;
    int checks = 0, failures = 0, n;

    always #5 clk = ~clk;

    rv32i_memory_access #(.MISALIGN_TRAP(1), .RVALID_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .execute_valid(execute_valid), .execute_load(execute_load),
        .execute_store(execute_store), .execute_reg_write(execute_reg_write), .execute_funct3(execute_funct3),
        .execute_rd(execute_rd), .execute_alu_result(execute_alu_result), .execute_rs2_data(execute_rs2_data),
        .dmem_req(req), .dmem_gnt(dmem_gnt), .dmem_we(we), .dmem_be(be), .dmem_addr(addr), .dmem_wdata(wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .memory_stall(stall), .memory_wb_en(wb_en),
        .memory_rd(rd), .memory_wb_data(wb_data), .memory_misaligned(mis), .memory_bus_error(berr));

    rv32i_memory_access #(.MISALIGN_TRAP(0), .RVALID_TIMEOUT(0)) dut2 (
        .clk(clk), .reset(reset), .execute_valid(execute_valid), .execute_load(execute_load),
        .execute_store(execute_store), .execute_reg_write(execute_reg_write), .execute_funct3(execute_funct3),
        .execute_rd(execute_rd), .execute_alu_result(execute_alu_result), .execute_rs2_data(execute_rs2_data),
        .dmem_req(req2), .dmem_gnt(dmem_gnt), .dmem_we(we2), .dmem_be(be2), .dmem_addr(addr2), .dmem_wdata(wdata2),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .memory_stall(stall2), .memory_wb_en(wb_en2),
        .memory_rd(rd2), .memory_wb_data(wb_data2), .memory_misaligned(mis2), .memory_bus_error(berr2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                         input logic [4:0] r, input logic [31:0] alu, input logic [31:0] rs2);
        execute_valid = 1; execute_load = ld; execute_store = st; execute_reg_write = rw;
        execute_funct3 = f3; execute_rd = r; execute_alu_result = alu; execute_rs2_data = rs2;
        tick();
        execute_valid = 0; execute_load = 0; execute_store = 0; execute_reg_write = 0;
    endtask

    task automatic load_fast(input string tag, input logic [2:0] f3, input logic [4:0] r,
                             input logic [31:0] a, input logic [31:0] rdata,
                             input logic exp_en, input logic [31:0] exp_data);
        issue(1, 0, 1, f3, r, a, 0);
        dmem_gnt = 1; tick(); dmem_gnt = 0;
        dmem_rvalid = 1; dmem_rdata = rdata; tick(); dmem_rvalid = 0;
        check({tag, "_wb_en"}, 32'(wb_en), 32'(exp_en));
        if (exp_en) check({tag, "_data"}, wb_data, exp_data);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(0, 1, 0, f3, 0, a, rs2);
        check({tag, "_req"}, 32'(req), 1);
        check({tag, "_we"}, 32'(we), 1);
        check({tag, "_be"}, 32'(be), 32'(exp_be));
        check({tag, "_wdata"}, wdata, exp_wd);
        check({tag, "_addr"}, addr, {a[31:2], 2'b00});
        dmem_gnt = 1; tick(); dmem_gnt = 0;
        check({tag, "_stall_done"}, 32'(stall), 0);
        check({tag, "_wb_en"}, 32'(wb_en), 0);
    endtask

    initial begin
        tick(); tick();
        reset = 0;
        check("rst_req", 32'(req), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_wb_en", 32'(wb_en), 0);
        check("rst_addr", addr, 0);

        issue(0, 0, 1, 3'b000, 5, 32'h1234, 0);
        check("add_wb_en", 32'(wb_en), 1);
        check("add_rd", 32'(rd), 5);
        check("add_data", wb_data, 32'h1234);
        check("add_stall", 32'(stall), 0);
        tick();
        check("add_pulse", 32'(wb_en), 0);
        issue(0, 0, 1, 3'b000, 0, 32'h55, 0);
        check("add_x0", 32'(wb_en), 0);

        store_chk("sb", 3'b000, 32'h1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
        store_chk("sh", 3'b001, 32'h1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_chk("sw", 3'b010, 32'h1004, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);

        issue(1, 0, 1, 3'b000, 7, 32'h2002, 0);
        check("lb_req1", 32'(req), 1);
        tick();
        check("lb_req2", 32'(req), 1);
        check("lb_be", 32'(be), 32'(4'b0100));
        dmem_gnt = 1; tick(); dmem_gnt = 0;
        check("lb_wait_req", 32'(req), 0);
        check("lb_wait_stall", 32'(stall), 1);
        tick();
        dmem_rvalid = 1; dmem_rdata = 32'h0080_0000; tick(); dmem_rvalid = 0;
        check("lb_wb_en", 32'(wb_en), 1);
        check("lb_rd", 32'(rd), 7);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_stall", 32'(stall), 0);

        load_fast("lbu", 3'b100, 7, 32'h2002, 32'h0080_0000, 1, 32'h0000_0080);
        load_fast("lh", 3'b001, 8, 32'h2002, 32'h8001_0000, 1, 32'hFFFF_8001);
        load_fast("lhu", 3'b101, 8, 32'h2000, 32'h1234_9ABC, 1, 32'h0000_9ABC);
        load_fast("lw", 3'b010, 6, 32'h2000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        load_fast("lw_x0", 3'b010, 0, 32'h2000, 32'hDEAD_BEEF, 0, 0);

        issue(1, 0, 1, 3'b010, 9, 32'h3001, 0);
        check("mis_pulse", 32'(mis), 1);
        check("mis_req", 32'(req), 0);
        check("mis_stall", 32'(stall), 0);
        check("mis_wb_en", 32'(wb_en), 0);
        check("nt_req", 32'(req2), 1);
        check("nt_addr", addr2, 32'h3000);
        check("nt_be", 32'(be2), 32'hF);
        dmem_gnt = 1; tick(); dmem_gnt = 0;
        check("mis_once", 32'(mis), 0);
        check("mis_gnt_ignored", 32'(stall), 0);
        dmem_rvalid = 1; dmem_rdata = 32'h1122_3344; tick(); dmem_rvalid = 0;
        check("nt_wb_en", 32'(wb_en2), 1);
        check("nt_data", wb_data2, 32'h1122_3344);
        check("mis_rvalid_ignored", 32'(wb_en), 0);

        issue(1, 0, 1, 3'b010, 3, 32'h4000, 0);
        n = 0;
        dmem_gnt = 1; tick(); dmem_gnt = 0; n++;
        while (!berr && n < 20) begin
            tick(); n++;
        end
        check("to_cycles", 32'(n), 8);
        check("to_stall", 32'(stall), 0);
        check("to_req", 32'(req), 0);
        check("to_wb_en", 32'(wb_en), 0);
        tick();
        check("to_pulse", 32'(berr), 0);

        issue(1, 0, 1, 3'b010, 4, 32'h5000, 0);
        dmem_gnt = 1; tick(); dmem_gnt = 0;
        check("rw_in_wait", 32'(stall), 1);
        reset = 1; tick(); reset = 0;
        check("rw_stall", 32'(stall), 0);
        check("rw_addr", addr, 0);
        check("rw_be", 32'(be), 0);
        check("rw_rd", 32'(rd), 0);
        check("rw_data", wb_data, 0);
        check("rw_stall2", 32'(stall2), 0);
        dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF; tick(); dmem_rvalid = 0;
        check("rw_late_rvalid", 32'(wb_en), 0);
        check("rw_late_data", wb_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
